// File: rtl/fft_pkg.sv
// Shared definitions for the FFT output reorder stage.
// Contents: default geometry, reorder state encoding, read-pipeline tag
// struct and the bit-reversal helper used to map write indices to addresses.
package fft_pkg;

  localparam int unsigned DEF_LGWIDTH = 10;
  localparam int unsigned DEF_OWIDTH  = 16;
  localparam int unsigned DEF_FCW     = 16;

  // Reorder control states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } state_t;

  // Framing flags travelling alongside a sample through the read pipeline
  typedef struct packed {
    logic valid;
    logic sync;
    logic last;
  } rd_tag_t;

  // Reverse the low lg bits of k; bits at and above lg come back as zero
  function automatic logic [31:0] bitrev(input logic [31:0] k, input int unsigned lg);
    logic [31:0] r;
    r = '0;
    for (int unsigned i = 0; i < lg; i++) begin
      r[5'(i)] = k[5'(lg - 1 - i)];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_pingpong_ram.sv
// Ping-pong frame buffer: simple dual-port RAM holding two frames.
// The address MSB selects the bank; the lower bits index within the frame.
// No reset so that it maps onto block RAM.
// Ports:
//   clk    clock
//   we     write enable
//   waddr  write address {bank, index}
//   wdata  write data
//   re     read enable; rdata updates only when high
//   raddr  read address {bank, index}
//   rdata  registered read data
module fft_pingpong_ram #(
  parameter int unsigned AW = 11,
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read port
  always_ff @(posedge clk) begin
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/fft_reorder.sv
// Bit-reversal reorder and framing stage for the pipelined FFT output.
// Accepts one bit-reversed-order sample per i_ce and emits the previous
// complete frame in natural bin order, optionally fftshifted.
// Build option: define FFT_FRAMECNT_EN to add the o_frame completed-frame counter.
// Ports:
//   i_clk      clock, rising edge
//   i_reset_n  asynchronous reset, active low
//   i_ce       clock enable; one sample in and one sample out per i_ce
//   i_sync     marks input sample 0 (bit-reversed index 0) of a frame
//   i_sample   {real, imag} input sample
//   i_shift    fftshift select, captured when a frame completes
//   o_result   {real, imag} natural-order output sample
//   o_sync     high with output bin 0
//   o_valid    o_result holds a sample of a completely written frame
//   o_last     high with output sample N-1
//   o_frame    completed-frame count (FFT_FRAMECNT_EN only)
module fft_reorder
  import fft_pkg::*;
#(
  parameter int unsigned LGWIDTH = DEF_LGWIDTH,
  parameter int unsigned OWIDTH  = DEF_OWIDTH
`ifdef FFT_FRAMECNT_EN
  ,
  parameter int unsigned FCW     = DEF_FCW
`endif
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  input  logic                i_ce,
  input  logic                i_sync,
  input  logic [2*OWIDTH-1:0] i_sample,
  input  logic                i_shift,
  output logic [2*OWIDTH-1:0] o_result,
  output logic                o_sync,
  output logic                o_valid,
  output logic                o_last
`ifdef FFT_FRAMECNT_EN
  ,
  output logic [FCW-1:0]      o_frame
`endif
);

  localparam int unsigned DW = 2 * OWIDTH;
  localparam int unsigned AW = LGWIDTH + 1;
  localparam logic [LGWIDTH-1:0] K_LAST     = '1;
  localparam logic [LGWIDTH-1:0] SHIFT_MASK = {1'b1, {(LGWIDTH-1){1'b0}}};

  state_t             state;
  state_t             state_nxt;
  logic [LGWIDTH-1:0] wr_cnt;
  logic [LGWIDTH-1:0] wr_k;
  logic [LGWIDTH-1:0] rd_addr;
  logic               wb;
  logic               rd_shift;
  logic               accept;
  logic               abort;
  logic               swap;
  rd_tag_t            rd_tag;
  rd_tag_t            s1_tag;
  logic [AW-1:0]      ram_waddr;
  logic [AW-1:0]      ram_raddr;
  logic [DW-1:0]      ram_q;

  // State register
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state <= IDLE;
    end else if (i_ce) begin
      state <= state_nxt;
    end
  end

  // Next state plus write-side control strobes
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    abort     = 1'b0;
    swap      = 1'b0;
    // A sync-tagged sample always lands at index 0
    wr_k      = i_sync ? '0 : wr_cnt;
    if (i_ce) begin
      case (state)
        IDLE: begin
          if (i_sync) begin
            accept    = 1'b1;
            state_nxt = FILL;
          end
        end
        FILL, RUN: begin
          accept = 1'b1;
          if (i_sync && (wr_cnt != '0)) begin
            // Resync mid-frame: drop the partial frame and refill
            abort     = 1'b1;
            state_nxt = FILL;
          end else if (wr_k == K_LAST) begin
            swap      = 1'b1;
            state_nxt = RUN;
          end
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  // Write counter, bank select and captured shift mode
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_cnt   <= '0;
      wb       <= 1'b0;
      rd_shift <= 1'b0;
    end else if (i_ce) begin
      if (accept) begin
        wr_cnt <= wr_k + LGWIDTH'(1);
      end
      if (swap) begin
        wb       <= ~wb;
        rd_shift <= i_shift;
      end
    end
  end

  // Read side follows the write index in the other bank
  always_comb begin
    rd_tag       = '0;
    rd_addr      = wr_cnt ^ (rd_shift ? SHIFT_MASK : '0);
    rd_tag.valid = (state == RUN);
    rd_tag.sync  = rd_tag.valid && (wr_cnt == '0);
    // An abort truncates the frame being read, so it never reaches its last sample
    rd_tag.last  = rd_tag.valid && (wr_cnt == K_LAST) && !abort;
  end

  assign ram_waddr = {wb, LGWIDTH'(bitrev(32'(wr_k), LGWIDTH))};
  assign ram_raddr = {~wb, rd_addr};

  fft_pingpong_ram #(
    .AW (AW),
    .DW (DW)
  ) u_ram (
    .clk   (i_clk),
    .we    (accept),
    .waddr (ram_waddr),
    .wdata (i_sample),
    .re    (i_ce),
    .raddr (ram_raddr),
    .rdata (ram_q)
  );

  // Tag stage aligned with the registered RAM read
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      s1_tag <= '0;
    end else if (i_ce) begin
      s1_tag <= rd_tag;
    end
  end

  // Output register
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_result <= '0;
      o_valid  <= 1'b0;
      o_sync   <= 1'b0;
      o_last   <= 1'b0;
    end else if (i_ce) begin
      o_result <= s1_tag.valid ? ram_q : '0;
      o_valid  <= s1_tag.valid;
      o_sync   <= s1_tag.sync;
      o_last   <= s1_tag.last;
    end
  end

`ifdef FFT_FRAMECNT_EN
  // Completed-frame counter, advancing together with o_last
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_frame <= '0;
    end else if (i_ce) begin
      if (abort) begin
        o_frame <= '0;
      end else if (s1_tag.last) begin
        o_frame <= o_frame + FCW'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_fft_reorder.sv
// Self-checking bench for fft_reorder (LGWIDTH=3, OWIDTH=16).
// A frame-level reference model schedules each completed frame's natural-order
// outputs two enables after completion; table vectors and hand sequences
// cover the basic frame, fftshift, i_ce gaps, resync abort and async reset.
module tb_fft_reorder;

  localparam int unsigned LG = 3;
  localparam int unsigned N  = 8;
  localparam int unsigned OW = 16;
`ifdef FFT_FRAMECNT_EN
  localparam int unsigned FCW = 2;
`endif

  logic          i_clk;
  logic          i_reset_n;
  logic          i_ce;
  logic          i_sync;
  logic [2*OW-1:0] i_sample;
  logic          i_shift;
  logic [2*OW-1:0] o_result;
  logic          o_sync;
  logic          o_valid;
  logic          o_last;
`ifdef FFT_FRAMECNT_EN
  logic [FCW-1:0] o_frame;
`endif

  fft_reorder #(
    .LGWIDTH (LG),
    .OWIDTH  (OW)
`ifdef FFT_FRAMECNT_EN
    ,
    .FCW     (FCW)
`endif
  ) dut (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_ce      (i_ce),
    .i_sync    (i_sync),
    .i_sample  (i_sample),
    .i_shift   (i_shift),
    .o_result  (o_result),
    .o_sync    (o_sync),
    .o_valid   (o_valid),
    .o_last    (o_last)
`ifdef FFT_FRAMECNT_EN
    ,
    .o_frame   (o_frame)
`endif
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  typedef struct packed {
    logic        valid;
    logic        sync;
    logic        last;
    logic [31:0] data;
  } out_t;

  typedef struct packed {
    logic        sync;
    logic [31:0] sample;
    logic        ev;
    logic        es;
    logic        el;
    logic [15:0] eval;
  } vec_t;

  int n_checks;
  int n_fail;

  // Reference model state
  out_t        sched [int];
  out_t        cur;
  int          ce_idx;
  bit          m_active;
  int          m_k;
  logic [31:0] m_buf [N];
`ifdef FFT_FRAMECNT_EN
  int          m_frame;
`endif

  function automatic int brev(input int k);
    int r;
    int v;
    r = 0;
    v = k;
    for (int i = 0; i < int'(LG); i++) begin
      r = r * 2 + (v % 2);
      v = v / 2;
    end
    return r;
  endfunction

  function automatic logic [31:0] mk_sample(input int v);
    return {16'(v), 16'(255 - v)};
  endfunction

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    sched.delete();
    cur      = '0;
    m_active = 1'b0;
    m_k      = 0;
`ifdef FFT_FRAMECNT_EN
    m_frame  = 0;
`endif
  endtask

  // One accepted enable: emit what was scheduled, then apply the write rules
  task automatic model_edge(input logic sync, input logic shift, input logic [31:0] sample);
    int   e;
    bit   abort;
    bit   wr;
    out_t t;
    e     = ce_idx;
    abort = 1'b0;
    wr    = 1'b0;
    if (sched.exists(e)) begin
      cur = sched[e];
      sched.delete(e);
    end else begin
      cur = '0;
    end
    if (!m_active) begin
      if (sync) begin
        m_active = 1'b1;
        m_k      = 0;
        wr       = 1'b1;
      end
    end else begin
      wr = 1'b1;
      if (sync) begin
        abort = (m_k != 0);
        m_k   = 0;
      end
    end
    if (abort) begin
      for (int j = e + 2; j <= e + int'(N) + 2; j++) begin
        if (sched.exists(j)) sched.delete(j);
      end
      if (sched.exists(e + 1)) begin
        t      = sched[e + 1];
        t.last = 1'b0;
        sched[e + 1] = t;
      end
    end
    if (wr) begin
      m_buf[brev(m_k)] = sample;
      if (m_k == int'(N) - 1) begin
        for (int n = 0; n < int'(N); n++) begin
          t.valid = 1'b1;
          t.sync  = (n == 0);
          t.last  = (n == int'(N) - 1);
          t.data  = m_buf[shift ? (n + int'(N) / 2) % int'(N) : n];
          sched[e + 2 + n] = t;
        end
      end
      m_k = (m_k + 1) % int'(N);
    end
`ifdef FFT_FRAMECNT_EN
    if (abort) m_frame = 0;
    else if (cur.last) m_frame = (m_frame + 1) % (1 << FCW);
`endif
    ce_idx++;
  endtask

  task automatic step(input logic ce, input logic sync, input logic shift, input logic [31:0] sample);
    i_ce     = ce;
    i_sync   = sync;
    i_shift  = shift;
    i_sample = sample;
    @(posedge i_clk);
    #1;
    if (ce) model_edge(sync, shift, sample);
    check1("o_valid", o_valid, cur.valid);
    check1("o_sync", o_sync, cur.sync);
    check1("o_last", o_last, cur.last);
    if (cur.valid) check32("o_result", o_result, cur.data);
`ifdef FFT_FRAMECNT_EN
    check32("o_frame", 32'(o_frame), 32'(m_frame));
`endif
  endtask

  // Reset asserted between clock edges; outputs must clear at once
  task automatic do_reset();
    #3;
    i_ce      = 1'b0;
    i_sync    = 1'b0;
    i_shift   = 1'b0;
    i_sample  = '0;
    i_reset_n = 1'b0;
    #1;
    check1("rst_valid", o_valid, 1'b0);
    check1("rst_sync", o_sync, 1'b0);
    check1("rst_last", o_last, 1'b0);
    check32("rst_result", o_result, 32'h0);
`ifdef FFT_FRAMECNT_EN
    check32("rst_frame", 32'(o_frame), 32'h0);
`endif
    @(posedge i_clk);
    #1;
    i_reset_n = 1'b1;
    model_reset();
  endtask

  vec_t tbl [24];
  int   exp2 [8];
  int   acc;
  int   exp_next;
  int   pos;
  logic ce;
  logic sy;
  int   lasts;

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    ce_idx    = 0;
    i_reset_n = 1'b1;
    i_ce      = 1'b0;
    i_sync    = 1'b0;
    i_shift   = 1'b0;
    i_sample  = '0;
    model_reset();
    #1;

    // Basic frame ordering, table driven
    for (int i = 0; i < 24; i++) begin
      int f;
      int k;
      int v;
      int n;
      f = i / 8;
      k = i % 8;
      v = f * 8 + brev(k);
      tbl[i].sync   = (k == 0);
      tbl[i].sample = mk_sample(v);
      if (i >= int'(N) + 1) begin
        n = (i - 9) % 8;
        tbl[i].ev   = 1'b1;
        tbl[i].es   = (n == 0);
        tbl[i].el   = (n == 7);
        tbl[i].eval = 16'(((i - 9) / 8) * 8 + n);
      end else begin
        tbl[i].ev   = 1'b0;
        tbl[i].es   = 1'b0;
        tbl[i].el   = 1'b0;
        tbl[i].eval = '0;
      end
    end
    do_reset();
    for (int i = 0; i < 24; i++) begin
      step(1'b1, tbl[i].sync, 1'b0, tbl[i].sample);
      check1("tbl_valid", o_valid, tbl[i].ev);
      check1("tbl_sync", o_sync, tbl[i].es);
      check1("tbl_last", o_last, tbl[i].el);
      if (tbl[i].ev) check32("tbl_value", 32'(o_result[31:16]), 32'(tbl[i].eval));
    end

    // fftshift captured at the swap; toggling it mid-read has no effect
    exp2 = '{4, 5, 6, 7, 0, 1, 2, 3};
    do_reset();
    for (int i = 0; i < 24; i++) begin
      int   k;
      logic sh;
      k = i % 8;
      if (i < 8) sh = (k == 7);
      else if (i < 16) sh = (k == 7) ? 1'b0 : 1'($urandom_range(0, 1));
      else sh = 1'b0;
      step(1'b1, (k == 0), sh, mk_sample((i / 8) * 8 + brev(k)));
      if (i >= 9 && i <= 16) check32("shift_order", 32'(o_result[31:16]), 32'(exp2[i - 9]));
      if (i == 9) check1("shift_sync", o_sync, 1'b1);
    end

    // Gapped i_ce: same natural-order stream, changing only on enables
    do_reset();
    acc      = 0;
    exp_next = 0;
    for (int j = 0; j < 200; j++) begin
      ce = 1'($urandom_range(0, 1));
      if (ce) begin
        step(1'b1, ((acc % 8) == 0), 1'b0, mk_sample((acc / 8) * 8 + brev(acc % 8)));
        acc++;
        if (o_valid) begin
          check32("gap_order", 32'(o_result[31:16]), 32'(16'(exp_next)));
          exp_next++;
        end
      end else begin
        step(1'b0, 1'($urandom_range(0, 1)), 1'b0, $urandom);
      end
    end

    // Resync at k=5: o_valid drops two enables later, no o_last, refill latency
    do_reset();
    pos = 0;
    for (int j = 0; j < 40; j++) begin
      sy = (pos == 0) || (j == 21);
      step(1'b1, sy, 1'b0, $urandom);
      pos = sy ? 1 : (pos + 1) % 8;
      if (j == 22) check1("abort_valid_hold", o_valid, 1'b1);
      if (j == 23) check1("abort_valid_drop", o_valid, 1'b0);
      if (j >= 21 && j <= 29) check1("abort_no_last", o_last, 1'b0);
      if (j == 30) check1("resync_latency", o_sync, 1'b1);
    end

    // Async reset mid-RUN, then unsynced samples are ignored
    for (int j = 0; j < 6; j++) step(1'b1, 1'b0, 1'b0, $urandom);
    do_reset();
    for (int j = 0; j < 12; j++) begin
      step(1'b1, 1'b0, 1'b0, $urandom);
      check1("post_rst_idle", o_valid, 1'b0);
    end
    for (int j = 0; j < 24; j++) step(1'b1, ((j % 8) == 0), 1'b0, $urandom);

    // Frame counter over several frames, including wrap
    do_reset();
    lasts = 0;
    for (int j = 0; j < 6 * int'(N) + 2; j++) begin
      step(1'b1, ((j % 8) == 0), 1'b0, $urandom);
      if (o_last) begin
        lasts++;
`ifdef FFT_FRAMECNT_EN
        check32("frame_count", 32'(o_frame), 32'(lasts % (1 << FCW)));
`endif
      end
    end
    check32("frames_read", 32'(lasts), 32'd5);

    // Randomized traffic: gaps, free-run wraps, stray syncs, shift changes
    do_reset();
    pos = 0;
    for (int j = 0; j < 800; j++) begin
      if (j == 400) do_reset();
      ce = ($urandom_range(0, 9) < 7);
      if (pos == 0) sy = ($urandom_range(0, 9) != 0);
      else sy = ($urandom_range(0, 49) == 0);
      step(ce, sy, 1'($urandom_range(0, 1)), $urandom);
      if (ce) pos = sy ? 1 : (pos + 1) % 8;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
